// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fb_pkg
// Description : Framebuffer geometry, fill-engine register map and FSM state
//               type shared by the rectangle-fill engine.
// Revision    : 1.0  initial release
// ============================================================================
package fb_pkg;

  localparam int FB_WIDTH         = 640;
  localparam int FB_HEIGHT        = 480;
  localparam int FB_WORDS_PER_ROW = 20;

  // Avalon register offsets
  localparam logic [2:0] REG_X0     = 3'd0;
  localparam logic [2:0] REG_Y0     = 3'd1;
  localparam logic [2:0] REG_W      = 3'd2;
  localparam logic [2:0] REG_H      = 3'd3;
  localparam logic [2:0] REG_CTRL   = 3'd4;
  localparam logic [2:0] REG_STATUS = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_READ  = 3'd2,
    ST_MERGE = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } fb_state_t;

  // True when every pixel of word column col lies inside [x0, xe].
  function automatic logic fb_full_word(input logic [4:0] col,
                                        input logic [9:0] x0,
                                        input logic [9:0] xe);
    return ((col != x0[9:5]) || (x0[4:0] == 5'd0)) &&
           ((col != xe[9:5]) || (xe[4:0] == 5'd31));
  endfunction

endpackage
`default_nettype wire

// File: rtl/fb_edge_mask.sv
`default_nettype none
// ============================================================================
// Module      : fb_edge_mask
// Description : Combinational pixel mask for one 32-pixel word; bit i is set
//               when lo <= i <= hi.
// Revision    : 1.0  initial release
// ============================================================================
module fb_edge_mask (
  input  logic [4:0]  lo,
  input  logic [4:0]  hi,
  output logic [31:0] mask
);

  for (genvar i = 0; i < 32; i++) begin : g_bit
    assign mask[i] = (5'(i) >= lo) && (5'(i) <= hi);
  end

endmodule
`default_nettype wire

// File: rtl/fb_rect_fill.sv
`default_nettype none
// ============================================================================
// Module      : fb_rect_fill
// Description : Avalon-MM rectangle-fill engine for the 640x480 1-bpp
//               framebuffer. Clips the rectangle to the screen and performs a
//               read-modify-write of every affected 32-pixel word.
//               Optional macro FB_FILL_FULLWORD_BYPASS_EN: words whose mask is
//               all ones are written directly without the read/merge cycles.
// Revision    : 1.0  initial release
// ============================================================================
module fb_rect_fill
  import fb_pkg::*;
(
  input  logic        clk50,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [2:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        busy,
  output logic [14:0] fb_address,
  output logic [31:0] fb_writedata,
  output logic        fb_write,
  output logic [14:0] fb_rdaddress,
  input  logic [31:0] fb_readdata
);

  // Shadow registers (CPU visible)
  logic [9:0]  r_x0;
  logic [8:0]  r_y0;
  logic [10:0] r_w;
  logic [9:0]  r_h;
  logic        r_color;
  logic        r_done_flag;
  logic        r_empty_flag;

  // Bounds latched for the active fill
  logic [9:0]  r_fx0;
  logic [9:0]  r_fxe;
  logic [8:0]  r_fye;
  logic        r_fcolor;
  logic        r_fempty;

  // Walk position and merged write data
  logic [4:0]  r_col;
  logic [8:0]  r_row;
  logic [14:0] r_row_base;
  logic [31:0] r_wdata;

  fb_state_t   r_state;
  fb_state_t   w_state_next;

  logic        w_reg_wr;
  logic        w_start;
  logic [11:0] w_xsum;
  logic [11:0] w_ysum;
  logic [11:0] w_xend;
  logic [11:0] w_yend;
  logic [9:0]  w_xe;
  logic [8:0]  w_ye;
  logic        w_empty;
  logic [14:0] w_row_base_calc;
  logic [14:0] w_word_addr;
  logic [4:0]  w_lo;
  logic [4:0]  w_hi;
  logic [31:0] w_mask;
  logic        w_last_col;
  logic        w_last_row;

  assign w_reg_wr = chipselect & write;
  assign w_start  = w_reg_wr && (address == REG_CTRL) && writedata[1];

  // Clip against the screen; 12-bit sums cannot wrap for any register value.
  assign w_xsum = {2'b00, r_x0} + {1'b0, r_w};
  assign w_ysum = {3'b000, r_y0} + {2'b00, r_h};
  assign w_xend = (w_xsum > 12'(FB_WIDTH))  ? 12'(FB_WIDTH)  : w_xsum;
  assign w_yend = (w_ysum > 12'(FB_HEIGHT)) ? 12'(FB_HEIGHT) : w_ysum;
  assign w_xe   = 10'(w_xend - 12'd1);
  assign w_ye   = 9'(w_yend - 12'd1);
  assign w_empty = (r_w == 11'd0) || (r_h == 10'd0) ||
                   ({2'b00, r_x0} >= 12'(FB_WIDTH)) ||
                   ({3'b000, r_y0} >= 12'(FB_HEIGHT));

  // y*20 as shift-and-add so no multiplier is inferred
  assign w_row_base_calc = ({6'd0, r_y0} << 4) + ({6'd0, r_y0} << 2);

  assign w_word_addr = r_row_base + {10'd0, r_col};
  assign w_lo        = (r_col == r_fx0[9:5]) ? r_fx0[4:0] : 5'd0;
  assign w_hi        = (r_col == r_fxe[9:5]) ? r_fxe[4:0] : 5'd31;
  assign w_last_col  = (r_col == r_fxe[9:5]);
  assign w_last_row  = (r_row == r_fye);

  fb_edge_mask u_edge_mask (
    .lo   (w_lo),
    .hi   (w_hi),
    .mask (w_mask)
  );

`ifdef FB_FILL_FULLWORD_BYPASS_EN
  logic [4:0] w_next_col;
  logic       w_next_full;

  // Column and full-word test of the word the FSM moves to next
  always_comb begin
    w_next_col  = w_last_col ? r_fx0[9:5] : (r_col + 5'd1);
    w_next_full = fb_full_word(w_next_col, r_fx0, r_fxe);
    if (r_state == ST_SETUP) begin
      w_next_col  = r_x0[9:5];
      w_next_full = fb_full_word(r_x0[9:5], r_x0, w_xe);
    end
  end
`endif

  // FSM state register; reset aborts any fill immediately
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_start) w_state_next = ST_SETUP;
      ST_SETUP: begin
        if (w_empty) w_state_next = ST_DONE;
`ifdef FB_FILL_FULLWORD_BYPASS_EN
        else if (w_next_full) w_state_next = ST_WRITE;
`endif
        else w_state_next = ST_READ;
      end
      ST_READ:  w_state_next = ST_MERGE;
      ST_MERGE: w_state_next = ST_WRITE;
      ST_WRITE: begin
        if (w_last_col && w_last_row) w_state_next = ST_DONE;
`ifdef FB_FILL_FULLWORD_BYPASS_EN
        else if (w_next_full) w_state_next = ST_WRITE;
`endif
        else w_state_next = ST_READ;
      end
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  assign busy         = (r_state != ST_IDLE);
  assign fb_write     = (r_state == ST_WRITE);
  assign fb_address   = w_word_addr;
  assign fb_rdaddress = w_word_addr;
  assign fb_writedata = r_wdata;

  // Fill datapath: latch bounds in SETUP, merge in MERGE, step in WRITE
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      r_fx0      <= '0;
      r_fxe      <= '0;
      r_fye      <= '0;
      r_fcolor   <= 1'b0;
      r_fempty   <= 1'b0;
      r_col      <= '0;
      r_row      <= '0;
      r_row_base <= '0;
      r_wdata    <= '0;
    end else begin
      case (r_state)
        ST_SETUP: begin
          r_fx0      <= r_x0;
          r_fxe      <= w_xe;
          r_fye      <= w_ye;
          r_fcolor   <= r_color;
          r_fempty   <= w_empty;
          r_col      <= r_x0[9:5];
          r_row      <= r_y0;
          r_row_base <= w_row_base_calc;
`ifdef FB_FILL_FULLWORD_BYPASS_EN
          r_wdata    <= {32{r_color}};
`endif
        end
        ST_MERGE: begin
          r_wdata <= r_fcolor ? (fb_readdata | w_mask) : (fb_readdata & ~w_mask);
        end
        ST_WRITE: begin
          if (!w_last_col) begin
            r_col <= r_col + 5'd1;
          end else if (!w_last_row) begin
            r_col      <= r_fx0[9:5];
            r_row      <= r_row + 9'd1;
            r_row_base <= r_row_base + 15'(FB_WORDS_PER_ROW);
          end
`ifdef FB_FILL_FULLWORD_BYPASS_EN
          r_wdata <= {32{r_fcolor}};
`endif
        end
        default: ;
      endcase
    end
  end

  // CPU register file, sticky status flags and registered read port
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      r_x0         <= '0;
      r_y0         <= '0;
      r_w          <= '0;
      r_h          <= '0;
      r_color      <= 1'b0;
      r_done_flag  <= 1'b0;
      r_empty_flag <= 1'b0;
      readdata     <= '0;
    end else begin
      if (w_reg_wr) begin
        case (address)
          REG_X0:   r_x0 <= writedata[9:0];
          REG_Y0:   r_y0 <= writedata[8:0];
          REG_W:    r_w  <= writedata[10:0];
          REG_H:    r_h  <= writedata[9:0];
          REG_CTRL: begin
            r_color      <= writedata[0];
            r_done_flag  <= 1'b0;
            r_empty_flag <= 1'b0;
          end
          default: ;
        endcase
      end
      if (r_state == ST_DONE) begin
        r_done_flag <= 1'b1;
        if (r_fempty) r_empty_flag <= 1'b1;
      end
      if (chipselect && read) begin
        case (address)
          REG_X0:     readdata <= {22'd0, r_x0};
          REG_Y0:     readdata <= {23'd0, r_y0};
          REG_W:      readdata <= {21'd0, r_w};
          REG_H:      readdata <= {22'd0, r_h};
          REG_CTRL:   readdata <= {31'd0, r_color};
          REG_STATUS: readdata <= {29'd0, r_empty_flag, r_done_flag, busy};
          default:    readdata <= '0;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/fb_rect_fill.md
# fb_rect_fill

Hardware rectangle-fill engine that writes the 640x480 1-bpp VGA framebuffer, so software does not have to compute per-word pixel masks. The CPU programs an origin, size and colour over Avalon-MM and starts the engine. The engine clips the rectangle to the screen and does a read-modify-write of every affected 32-pixel word through the framebuffer RAM ports. It sits beside the VGA display peripheral and owns the framebuffer write port and a read port while busy; the top level muxes CPU writes onto that write port when busy=0.

## Interface
- No parameters. Geometry constants come from fb_pkg.
- clk50  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high
- chipselect  in  1  Avalon slave select
- write  in  1  Avalon write strobe
- read  in  1  Avalon read strobe
- address  in  3  register index
- writedata  in  32  Avalon write data
- readdata  out  32  Avalon read data, registered, 1-cycle read latency
- busy  out  1  engine active; top level grants the framebuffer write port to this block
- fb_address  out  15  framebuffer write word address
- fb_writedata  out  32  framebuffer write data
- fb_write  out  1  framebuffer write enable, one cycle per word
- fb_rdaddress  out  15  framebuffer read word address
- fb_readdata  in  32  framebuffer read data, valid one clk50 after fb_rdaddress is presented

## Operation
- Registers, each written when chipselect&write:
  - 0 X0[9:0]
  - 1 Y0[8:0]
  - 2 W[10:0]
  - 3 H[9:0]
  - 4 CTRL: bit0 COLOR (1=white), bit1 START (write-1 pulse, reads 0)
  - 5 STATUS, read-only: bit0 BUSY, bit1 DONE (sticky), bit2 EMPTY (sticky)
- Any write to CTRL clears DONE and EMPTY. Unused read bits are 0.
- Pixel mapping matches the display:
  - word address = y*20 + x[9:5]
  - bit index = x[4:0]
  - bit value 1 = white
- Clip: xe = min(X0+W, 640)-1 and ye = min(Y0+H, 480)-1. All arithmetic is 12 bits wide, so no wrap is possible.
- Empty rectangle: W=0, H=0, X0>=640 or Y0>=480. No framebuffer writes; DONE and EMPTY are set.
- FSM states: IDLE, SETUP, READ, MERGE, WRITE, DONE.
  - IDLE -> SETUP on START.
  - SETUP latches the clipped bounds. The row base is Y0*20, computed as (Y0<<4)+(Y0<<2). SETUP -> READ, or -> DONE if the rectangle is empty.
  - READ drives fb_rdaddress = row base + column.
  - MERGE registers the result: fb_readdata|mask when COLOR=1, fb_readdata&~mask when COLOR=0.
  - WRITE pulses fb_write with the registered data. It then advances the column. At xe[9:5] it moves to the next row: row base +20, column = X0[9:5]. After the last word it goes to DONE.
  - DONE sets DONE, -> IDLE.
- Row stepping adds 20 to the row base; the datapath has no multiplier in the loop.
- mask: bit i is set when lo <= i <= hi, where
  - lo = (col == X0[9:5]) ? X0[4:0] : 0
  - hi = (col == xe[9:5]) ? xe[4:0] : 31
- START while busy is ignored. Register writes while busy update the shadow registers only; the active fill uses the values latched in SETUP.
- Reset:
  - All registers and flags go to 0 and the FSM goes to IDLE.
  - fb_write, busy, readdata, fb_address, fb_writedata and fb_rdaddress are all 0.
  - Reset mid-fill aborts at once, leaving a partially filled rectangle. No write is issued after reset asserts.

## Timing
- START accepted on edge E0 -> SETUP during E0..E1, busy=1 from E0.
- Each word takes READ, MERGE, WRITE: 3 cycles. Total busy = 2 + 3*N cycles, with SETUP and DONE included.
- An empty rectangle takes 2 busy cycles: SETUP and DONE.
- fb_write is high only in WRITE. fb_address and fb_writedata are stable that cycle.
- STATUS DONE is readable on the first read issued after busy falls.

## Configuration
- FB_FILL_FULLWORD_BYPASS_EN
  - Defined: a word whose mask is 0xFFFFFFFF skips READ and MERGE. It goes straight to WRITE with data 0xFFFFFFFF or 0x00000000, so it costs 1 cycle.
  - Undefined: every word takes 3 cycles and is always read-modify-write.
  - Written framebuffer contents are identical in both builds.

## Structure
- fb_pkg holds:
  - FB_WIDTH=640, FB_HEIGHT=480, FB_WORDS_PER_ROW=20
  - the register offset constants
  - the state enum typedef
- Sub-module fb_edge_mask: combinational, takes lo[4:0] and hi[4:0] and returns the 32-bit mask.

## Test plan
- Reset: assert reset mid-fill -> fb_write=0 immediately, busy=0, STATUS reads 0.
- X0=0, Y0=0, W=32, H=1, COLOR=1 -> exactly one write, addr 0, data 0xFFFFFFFF. Busy for 5 cycles, or 3 with the bypass macro.
- Straddle: framebuffer all 0, X0=30, Y0=2, W=4, H=1, COLOR=1 -> two writes: addr 40 data 0xC0000000, then addr 41 data 0x00000003.
- Clip: framebuffer all 1s, X0=630, Y0=479, W=20, H=5, COLOR=0 -> single write, addr 9599, data 0x003FFFFF. DONE=1, EMPTY=0.
- W=0 -> no fb_write, busy for 2 cycles, STATUS=0x6.
- START written again during a fill at X0=0, Y0=0, W=64, H=2 -> ignored. Exactly 4 writes, to addrs 0, 1, 20, 21.
